// File: rtl/multi_or_wake_agg.sv
// Wake-request aggregator: per-channel glitch filter, level or sticky status,
// OR-reduced wake output, rising-edge pulse and lowest-index capture.
module multi_or_wake_agg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned FILT  = 3
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [WIDTH-1:0]                         in,
   input  logic [WIDTH-1:0]                         mask,
   input  logic                                     sticky,
   input  logic                                     clr,
   output logic [WIDTH-1:0]                         status,
   output logic                                     out,
   output logic                                     rise,
   output logic [((WIDTH > 2) ? $clog2(WIDTH) : 1)-1:0] first_id
);

   localparam int unsigned CW = $clog2(FILT + 1);
   localparam int unsigned IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] FiltVal = CW'(FILT);

   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [WIDTH-1:0] qual;
   logic [WIDTH-1:0] set_v;
   logic [WIDTH-1:0] status_q, status_d;
   logic             rise_q, rise_d;
   logic [IW-1:0]    first_id_q, first_id_d;
   logic [IW-1:0]    lowest;

   // Filter counters: count consecutive high samples, saturate at FILT, clear on low.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (in[i]) begin
            cnt_d[i] = (cnt_q[i] == FiltVal) ? cnt_q[i] : cnt_q[i] + CW'(1);
         end
         qual[i] = (cnt_q[i] == FiltVal);
      end
   end

   // Status next state; a fresh qualified event always wins over clr.
   always_comb begin
      set_v = qual & mask;
      if (sticky) begin
         status_d = (status_q & ~{WIDTH{clr}}) | set_v;
      end else begin
         status_d = set_v;
      end
   end

   // Rise fires only on an all-zero to non-zero transition of status.
   always_comb begin
      lowest = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (status_d[i]) begin
            lowest = IW'(i);
         end
      end
      rise_d     = (status_q == '0) && (status_d != '0);
      first_id_d = rise_d ? lowest : first_id_q;
   end

   // State registers with synchronous reset taking priority over all inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         status_q   <= '0;
         rise_q     <= 1'b0;
         first_id_q <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         status_q   <= status_d;
         rise_q     <= rise_d;
         first_id_q <= first_id_d;
      end
   end

   // Outputs come straight from registers; out has no path from in.
   always_comb begin
      status   = status_q;
      out      = |status_q;
      rise     = rise_q;
      first_id = first_id_q;
   end

endmodule

// File: tb/tb_multi_or_wake_agg.sv
module tb_multi_or_wake_agg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned FILT  = 3;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] mask;
   logic             sticky;
   logic             clr;
   logic [WIDTH-1:0] status;
   logic             out;
   logic             rise;
   logic [2:0]       first_id;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic [7:0] in;
      logic [7:0] mask;
      logic       sticky;
      logic       clr;
      logic [7:0] exp_status;
      logic       exp_out;
      logic       exp_rise;
      logic [2:0] exp_fid;
      string      name;
   } vec_t;

   vec_t vecs[$];

   multi_or_wake_agg #(
      .WIDTH(WIDTH),
      .FILT (FILT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in      (in),
      .mask    (mask),
      .sticky  (sticky),
      .clr     (clr),
      .status  (status),
      .out     (out),
      .rise    (rise),
      .first_id(first_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input int n, input logic r, input logic [7:0] i, input logic [7:0] m,
                      input logic s, input logic c, input logic [7:0] st, input logic ri,
                      input logic [2:0] fid, input string nm);
      vec_t v;
      v.rst = r; v.in = i; v.mask = m; v.sticky = s; v.clr = c;
      v.exp_status = st; v.exp_out = (st != 8'h00); v.exp_rise = ri; v.exp_fid = fid;
      v.name = nm;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Apply inputs away from the edge, then sample just after the edge.
   task automatic step(input logic r, input logic [7:0] i, input logic [7:0] m,
                       input logic s, input logic c);
      @(negedge clk);
      rst = r; in = i; mask = m; sticky = s; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input logic [7:0] st, input logic ri,
                          input logic [2:0] fid);
      chk({nm, ".status"}, 32'(status), 32'(st));
      chk({nm, ".out"}, 32'(out), 32'(st != 8'h00));
      chk({nm, ".rise"}, 32'(rise), 32'(ri));
      chk({nm, ".first_id"}, 32'(first_id), 32'(fid));
   endtask

   initial begin
      rst = 1'b1; in = '0; mask = '0; sticky = 1'b0; clr = 1'b0;

      //   n  rst in     mask   stk clr status rise fid name
      add(1,  1, 8'h00, 8'hFF, 1, 0, 8'h00, 0, 0, "reset");
      add(3,  0, 8'h04, 8'hFF, 1, 0, 8'h00, 0, 0, "a_filt");
      add(1,  0, 8'h04, 8'hFF, 1, 0, 8'h04, 1, 2, "a_qual");
      add(2,  0, 8'h00, 8'hFF, 1, 0, 8'h04, 0, 2, "a_hold");
      add(1,  0, 8'h00, 8'hFF, 1, 1, 8'h00, 0, 2, "b_clr");
      add(2,  0, 8'h20, 8'hFF, 1, 0, 8'h00, 0, 2, "b_short");
      add(2,  0, 8'h00, 8'hFF, 1, 0, 8'h00, 0, 2, "b_drop");
      add(3,  0, 8'h30, 8'hFF, 1, 0, 8'h00, 0, 2, "c_filt");
      add(1,  0, 8'h30, 8'hFF, 1, 0, 8'h30, 1, 4, "c_qual");
      add(1,  0, 8'h00, 8'hFF, 1, 0, 8'h30, 0, 4, "c_drop");
      add(3,  0, 8'h80, 8'hFF, 1, 0, 8'h30, 0, 4, "c_filt7");
      add(1,  0, 8'h80, 8'hFF, 1, 1, 8'h80, 0, 4, "c_clr_set");
      add(1,  0, 8'h00, 8'hFF, 1, 0, 8'h80, 0, 4, "c_hold7");
      add(1,  0, 8'h00, 8'hFF, 1, 1, 8'h00, 0, 4, "c_clr");
      add(10, 0, 8'h01, 8'hFE, 1, 0, 8'h00, 0, 4, "d_masked");
      add(1,  0, 8'h01, 8'hFF, 1, 0, 8'h01, 1, 0, "d_unmask");
      add(1,  0, 8'h00, 8'hFF, 1, 0, 8'h01, 0, 0, "d_hold");
      add(1,  0, 8'h00, 8'hFF, 1, 1, 8'h00, 0, 0, "d_clr");
      add(3,  0, 8'h02, 8'hFF, 0, 0, 8'h00, 0, 0, "e_filt");
      add(1,  0, 8'h02, 8'hFF, 0, 0, 8'h02, 1, 1, "e_qual");
      add(1,  0, 8'h02, 8'hFF, 0, 1, 8'h02, 0, 1, "e_clr_ign");
      add(1,  0, 8'h00, 8'hFF, 0, 0, 8'h02, 0, 1, "e_drop1");
      add(1,  0, 8'h00, 8'hFF, 0, 0, 8'h00, 0, 1, "e_drop2");
      add(2,  0, 8'h08, 8'hFF, 1, 0, 8'h00, 0, 1, "f_pre");
      add(1,  1, 8'h08, 8'hFF, 1, 0, 8'h00, 0, 0, "f_rst");
      add(3,  0, 8'h08, 8'hFF, 1, 0, 8'h00, 0, 0, "f_refilt");
      add(1,  0, 8'h08, 8'hFF, 1, 0, 8'h08, 1, 3, "f_qual");
      add(1,  0, 8'h08, 8'hFF, 0, 0, 8'h08, 0, 3, "g_to_level");
      add(1,  0, 8'h08, 8'hFF, 1, 0, 8'h08, 0, 3, "g_to_sticky");
      add(1,  0, 8'h08, 8'h00, 1, 0, 8'h08, 0, 3, "g_mask_stk");
      add(1,  0, 8'h08, 8'h00, 0, 0, 8'h00, 0, 3, "g_mask_lvl");
      add(1,  0, 8'h08, 8'hFF, 0, 0, 8'h08, 1, 3, "g_remask");
      add(1,  1, 8'hFF, 8'hFF, 1, 1, 8'h00, 0, 0, "h_rst_prio");

      for (int v = 0; v < vecs.size(); v++) begin
         step(vecs[v].rst, vecs[v].in, vecs[v].mask, vecs[v].sticky, vecs[v].clr);
         chk({vecs[v].name, ".status"}, 32'(status), 32'(vecs[v].exp_status));
         chk({vecs[v].name, ".out"}, 32'(out), 32'(vecs[v].exp_out));
         chk({vecs[v].name, ".rise"}, 32'(rise), 32'(vecs[v].exp_rise));
         chk({vecs[v].name, ".first_id"}, 32'(first_id), 32'(vecs[v].exp_fid));
      end

      // Several channels qualifying together: lowest index captured.
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 8'hA4, 8'hFF, 1'b1, 1'b0);
         chk_all("m_filt", 8'h00, 1'b0, 3'd0);
      end
      step(1'b0, 8'hA4, 8'hFF, 1'b1, 1'b0);
      chk_all("m_qual", 8'hA4, 1'b1, 3'd2);
      // Later channel adds to a non-zero status: no rise, first_id held.
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 8'h01, 8'hFF, 1'b1, 1'b0);
      end
      chk_all("m_add", 8'hA5, 1'b0, 3'd2);
      step(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0);
      chk_all("m_hold", 8'hA5, 1'b0, 3'd2);
      step(1'b0, 8'h00, 8'hFF, 1'b1, 1'b1);
      chk_all("m_clr", 8'h00, 1'b0, 3'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_or_wake_agg.md
MULTI_OR_WAKE_AGG -- requirements
Module: multi_or_wake_agg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of wake channels, legal range 2..32.
REQ-002 SHALL have parameter FILT, default 3: consecutive high samples needed to qualify a channel, legal range 1..15.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in  input  WIDTH: raw wake request per channel.
REQ-006 SHALL have port mask  input  WIDTH: per-channel enable, 1 = channel may set status.
REQ-007 SHALL have port sticky  input  1: mode select, 1 = latched, 0 = level.
REQ-008 SHALL have port clr  input  1: clears latched status in sticky mode.
REQ-009 SHALL have port status  output  WIDTH: registered per-channel qualified-event flags.
REQ-010 SHALL have port out  output  1: OR-reduction of status.
REQ-011 SHALL have port rise  output  1: one-cycle pulse when out goes 0->1.
REQ-012 SHALL have port first_id  output  max(1,clog2(WIDTH)): lowest channel index that caused the latest rise.

Function
REQ-013 SHALL keep one saturating counter per channel, width clog2(FILT+1): +1 on each edge with in[i]=1, saturating at FILT; 0 on any edge with in[i]=0.
REQ-014 SHALL define q[i] = (counter[i] == FILT); counters run regardless of mask.
REQ-015 SHALL, with sticky=0, load status[i] <= q[i] & mask[i] on every edge.
REQ-016 SHALL, with sticky=1, set status[i] on any edge with q[i] & mask[i], and hold it until clr.
REQ-017 SHALL, with sticky=1 and clr=1, clear every status bit whose set condition is false that edge; set wins over clr for the same bit, so no event is lost.
REQ-018 SHALL ignore clr when sticky=0.
REQ-019 SHALL leave already-latched bits unchanged when mask drops in sticky mode; in level mode those bits clear on the next edge per REQ-015.
REQ-020 SHALL drive out = |status, combinational from the status register only, no path from in.
REQ-021 SHALL meet this latency: in[i] high before edge 1 and held -> status[i] and out high after edge FILT+1.
REQ-022 SHALL assert rise for exactly one cycle, registered, after the edge where status goes from all-zero to non-zero; rise is 0 otherwise.
REQ-023 SHALL load first_id with the lowest index among status bits set on that same edge, and hold it otherwise.
REQ-024 SHALL NOT pulse rise or update first_id when status stays non-zero across a clr; this covers clr cleared old bits while new bits set in the same cycle.
REQ-025 SHALL NOT assert rise when sticky changes while status stays non-zero.
REQ-026 SHALL NOT have any illegal or unreachable state; every counter value 0..FILT is valid.

Reset
REQ-027 SHALL, on any edge with rst=1, zero all counters, status, out, rise and first_id.
REQ-028 SHALL give rst priority over in, mask, clr and sticky, including mid-count.
REQ-029 SHALL restart qualification from zero after reset; a channel held high through reset qualifies FILT+1 edges after rst falls.

Verification (WIDTH=8, FILT=3)
REQ-030 SHALL cover: sticky=1, mask=0xFF, in=0x04 held -> after edge 4: status=0x04, out=1, rise=1 for one cycle, first_id=2; status held after in drops.
REQ-031 SHALL cover: in[5] high 2 edges then low -> status=0x00, out=0 and rise=0 throughout.
REQ-032 SHALL cover: sticky=1, in=0x30 qualifying on the same edge -> status=0x30, first_id=4; then clr=1 with in=0 -> status=0x00 and out=0 after the next edge; clr=1 coincident with in[7] qualifying -> status=0x80, no rise.
REQ-033 SHALL cover: mask=0xFE, in[0] held 10 edges -> out=0; then mask=0xFF -> status=0x01, rise=1 after the next edge.
REQ-034 SHALL cover: sticky=0, in[1] held 5 edges then dropped -> status=0x02 while qualified; status=0x00 and out=0 after the second edge following the drop.
REQ-035 SHALL cover: rst=1 pulsed when counter[3]=2 with in[3] held -> all outputs 0 after that edge; status[3] set only FILT+1=4 edges after rst deasserts.
